// File: rtl/vga_timing_param.sv
// Parametrised VGA/SVGA raster timing generator (default 800x600@60).
// Ports: pclk, rst (sync, active-high), ce -> hcount/vcount, sync, blanking, de, strobes.
module vga_timing_param #(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows use an inclusive last position so a zero back porch
  // with a full 2**CW total never needs an out-of-range constant.
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW ||
      H_ACTIVE == 0 || H_SYNC == 0 ||
      V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_params
    $error("vga_timing_param: invalid timing parameters");
  end

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic hb_q, hb_d;
  logic vb_q, vb_d;
  logic de_q, de_d;
  logic ls_q, ls_d;
  logic fs_q, fs_d;

  // Flags are decoded from the next counts so that, once registered,
  // they line up with the hcount/vcount they describe.
  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (ce) begin
      if (h_q == H_LAST) begin
        h_d  = '0;
        ls_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fs_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    hb_d = (h_d >= H_ACT);
    vb_d = (v_d >= V_ACT);
    de_d = !hb_d && !vb_d;
    hs_d = (h_d >= HS_BEG && h_d <= HS_END) ? HS_POL : !HS_POL;
    vs_d = (v_d >= VS_BEG && v_d <= VS_END) ? VS_POL : !VS_POL;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= !HS_POL;
      vs_q <= !VS_POL;
      hb_q <= 1'b0;
      vb_q <= 1'b0;
      de_q <= 1'b1;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      hb_q <= hb_d;
      vb_q <= vb_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign hblnk       = hb_q;
  assign vblnk       = vb_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param with a reduced raster (25x12, mixed polarity).
// Drives pclk/rst/ce, compares all outputs against hand-computed values.
module tb_vga_timing_param;

  localparam int CW = 6;

  logic          pclk = 1'b0;
  logic          rst;
  logic          ce;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          hblnk;
  logic          vblnk;
  logic          de;
  logic          line_start;
  logic          frame_start;

  // H: 16 active, fp 2, sync 3 (18..20), bp 4 -> 25
  // V: 6 active, fp 1, sync 2 (7..8), bp 3 -> 12
  vga_timing_param #(
    .CW(CW),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .ce(ce),
    .hcount(hcount),
    .vcount(vcount),
    .hsync(hsync),
    .vsync(vsync),
    .hblnk(hblnk),
    .vblnk(vblnk),
    .de(de),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int       n;
    logic [5:0] h;
    logic [5:0] v;
    logic     hs;
    logic     vs;
    logic     hb;
    logic     vb;
    logic     de;
    logic     ls;
    logic     fs;
  } vec_t;

  vec_t vecs[18];

  int checks = 0;
  int errors = 0;
  int de_bad = 0;
  int cyc    = 0;

  always @(negedge pclk) begin
    if (de !== (!hblnk && !vblnk)) de_bad <= de_bad + 1;
  end

  task automatic step(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {hcount, vcount, hsync, vsync, hblnk, vblnk,
            de, line_start, frame_start};
  endfunction

  int t0, t1, cnt, fsn, lsbad, holdbad, k;
  logic [CW-1:0] ph;
  logic pls;
  logic pat[4];

  initial begin
    rst = 1'b1;
    ce  = 1'b0;
    //            n    h   v  hs vs hb vb de ls fs
    vecs[0]  = '{  0,  0,  0, 1, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{ 15, 15,  0, 1, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{ 16, 16,  0, 1, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{ 17, 17,  0, 1, 0, 1, 0, 0, 0, 0};
    vecs[4]  = '{ 18, 18,  0, 0, 0, 1, 0, 0, 0, 0};
    vecs[5]  = '{ 20, 20,  0, 0, 0, 1, 0, 0, 0, 0};
    vecs[6]  = '{ 21, 21,  0, 1, 0, 1, 0, 0, 0, 0};
    vecs[7]  = '{ 24, 24,  0, 1, 0, 1, 0, 0, 0, 0};
    vecs[8]  = '{ 25,  0,  1, 1, 0, 0, 0, 1, 1, 0};
    vecs[9]  = '{149, 24,  5, 1, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{150,  0,  6, 1, 0, 0, 1, 0, 1, 0};
    vecs[11] = '{175,  0,  7, 1, 1, 0, 1, 0, 1, 0};
    vecs[12] = '{199, 24,  7, 1, 1, 1, 1, 0, 0, 0};
    vecs[13] = '{218, 18,  8, 0, 1, 1, 1, 0, 0, 0};
    vecs[14] = '{225,  0,  9, 1, 0, 0, 1, 0, 1, 0};
    vecs[15] = '{299, 24, 11, 1, 0, 1, 1, 0, 0, 0};
    vecs[16] = '{300,  0,  0, 1, 0, 0, 0, 1, 1, 1};
    vecs[17] = '{325,  0,  1, 1, 0, 0, 0, 1, 1, 0};

    foreach (vecs[i]) begin
      step(1'b1, 1'b1);
      for (int j = 0; j < vecs[i].n; j++) step(1'b0, 1'b1);
      chk($sformatf("vec%0d_n%0d", i, vecs[i].n), outs(),
          {vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs,
           vecs[i].hb, vecs[i].vb, vecs[i].de, vecs[i].ls,
           vecs[i].fs});
    end

    // strobe lasts one pclk and counts hold while ce is low
    step(1'b1, 1'b1);
    repeat (25) step(1'b0, 1'b1);
    chk("ls_on", {line_start, hcount, vcount}, {1'b1, 6'd0, 6'd1});
    step(1'b0, 1'b0);
    chk("ls_drop_hold", {line_start, frame_start, hcount, vcount},
        {1'b0, 1'b0, 6'd0, 6'd1});
    step(1'b0, 1'b0);
    chk("hold2", {line_start, hcount, vcount}, {1'b0, 6'd0, 6'd1});

    // line period with ce=1
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 100 && t1 < 0; i++) begin
      step(1'b0, 1'b1);
      if (line_start) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
      end
    end
    chk("line_period", t1 - t0, 25);

    // de count and frame_start count over one full frame
    step(1'b1, 1'b1);
    cnt = 0;
    fsn = 0;
    repeat (300) begin
      step(1'b0, 1'b1);
      if (de) cnt++;
      if (frame_start) fsn++;
    end
    chk("de_per_frame", cnt, 96);
    chk("fs_per_frame", fsn, 1);

    // reset mid-frame
    step(1'b1, 1'b1);
    repeat (135) step(1'b0, 1'b1);
    chk("pre_rst_pos", {hcount, vcount}, {6'd10, 6'd5});
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("rst_hold%0d", i), outs(),
          {6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    step(1'b0, 1'b1);
    chk("post_rst", {hcount, vcount, line_start, frame_start},
        {6'd1, 6'd0, 1'b0, 1'b0});
    fsn = 0;
    repeat (298) begin
      step(1'b0, 1'b1);
      if (frame_start) fsn++;
    end
    chk("no_fs_before_wrap", fsn, 0);
    step(1'b0, 1'b1);
    chk("fs_at_wrap", {frame_start, line_start, hcount, vcount},
        {1'b1, 1'b1, 6'd0, 6'd0});

    // ce pattern 1,0,0,1: half duty doubles the frame period
    pat[0] = 1'b1;
    pat[1] = 1'b0;
    pat[2] = 1'b0;
    pat[3] = 1'b1;
    step(1'b1, 1'b1);
    t0 = -1;
    t1 = -1;
    lsbad = 0;
    holdbad = 0;
    pls = 1'b0;
    ph = hcount;
    k = 0;
    while (k < 2000 && t1 < 0) begin
      step(1'b0, pat[k % 4]);
      if (!pat[k % 4] && hcount != ph) holdbad++;
      if (line_start && pls) lsbad++;
      if (!pat[k % 4] && (line_start || frame_start)) lsbad++;
      if (frame_start) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
      end
      pls = line_start;
      ph = hcount;
      k++;
    end
    chk("ce_frame_period", t1 - t0, 600);
    chk("ce_hold", holdbad, 0);
    chk("ce_strobe_width", lsbad, 0);

    chk("de_vs_blank", de_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
